// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings, Wishbone register map
// and line-level constants.
package uart_pkg;

   typedef enum logic [2:0] {
      RX_IDLE  = 3'd0,
      RX_START = 3'd1,
      RX_DATA  = 3'd2,
      RX_STOP  = 3'd3,
      RX_BREAK = 3'd4
   } rx_state_e;

   localparam logic [1:0] WB_ADDR_TX       = 2'h0;
   localparam logic [1:0] WB_ADDR_RX       = 2'h1;
   localparam logic [1:0] WB_ADDR_FREQ_DIV = 2'h2;

   localparam logic HIGH = 1'b1;
   localparam logic LOW  = 1'b0;

   localparam int DEFAULT_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input; both flops
// reset to 1 so an idle-high line looks idle straight out of reset.
module uart_sync2 (
   input  logic clk,
   input  logic reset,
   input  logic d_in,
   output logic q_out
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d_in;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q_out = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART serial receiver: oversampled start/data/stop detection on the shared
// sample_tick strobe, producing FIFO push, framing-error and overrun pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
   parameter int DATA_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sample_tick,
   input  logic                 rx_bit,
   input  logic                 fifo_full,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_push,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 rx_busy
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

   logic rx_s;

   rx_state_e            state_q, state_d;
   logic [TW-1:0]        tick_q, tick_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 push_q, push_d;
   logic                 ferr_q, ferr_d;
   logic                 ovr_q, ovr_d;

   uart_sync2 u_sync (
      .clk   (clk),
      .reset (reset),
      .d_in  (rx_bit),
      .q_out (rx_s)
   );

   always_comb begin
      state_d   = state_q;
      tick_d    = tick_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      rx_data_d = rx_data_q;
      push_d    = LOW;
      ferr_d    = LOW;
      ovr_d     = LOW;
      unique case (state_q)
         // Start detection does not wait for a tick, so a back-to-back
         // frame is caught on the very next clk after STOP.
         RX_IDLE: begin
            if (rx_s == LOW) begin
               tick_d  = '0;
               state_d = RX_START;
            end
         end
         RX_START: begin
            if (sample_tick) begin
               if (tick_q == TICK_MID) begin
                  tick_d  = '0;
                  bit_d   = '0;
                  state_d = (rx_s == LOW) ? RX_DATA : RX_IDLE;
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
         end
         RX_DATA: begin
            if (sample_tick) begin
               if (tick_q == TICK_LAST) begin
                  shift_d[bit_q] = rx_s;
                  tick_d         = '0;
                  if (bit_q == BIT_LAST) begin
                     state_d = RX_STOP;
                  end else begin
                     bit_d = bit_q + BW'(1);
                  end
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
         end
         RX_STOP: begin
            if (sample_tick) begin
               if (tick_q == TICK_LAST) begin
                  tick_d = '0;
                  bit_d  = '0;
                  if (rx_s == HIGH) begin
                     if (fifo_full) begin
                        ovr_d = HIGH;
                     end else begin
                        push_d    = HIGH;
                        rx_data_d = shift_q;
                     end
                     state_d = RX_IDLE;
                  end else begin
                     ferr_d  = HIGH;
                     state_d = RX_BREAK;
                  end
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
         end
         // A held-low line stays here, so a break reports one error only.
         RX_BREAK: begin
            if (rx_s == HIGH) begin
               state_d = RX_IDLE;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= RX_IDLE;
         tick_q    <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         rx_data_q <= '0;
         push_q    <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         tick_q    <= tick_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         rx_data_q <= rx_data_d;
         push_q    <= push_d;
         ferr_q    <= ferr_d;
         ovr_q     <= ovr_d;
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_push   = push_q;
   assign frame_err = ferr_q;
   assign overrun   = ovr_q;
   assign rx_busy   = (state_q != RX_IDLE);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the UART block: deserialises the asynchronous `rx_bit` line into bytes.
- Pushes each good byte into the RX FIFO that backs Wishbone address 0x01.
- Consumes the shared 16x-baud `uart_clock` strobe from the frequency divider; keeps its own bit-phase counter, so it needs no separate rx_clock.
- Flags framing errors and FIFO overruns as one-cycle pulses for status logging.

Parameters:
- OVERSAMPLE, 16, `sample_tick` strobes per bit period; must be even and ≥ 4.
- DATA_BITS, 8, data bits per frame, LSB first; no parity bit; one stop bit.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- sample_tick  input  1  one-clk-wide strobe at OVERSAMPLE × baud (`uart_clock`).
- rx_bit  input  1  raw serial line, asynchronous; idle high.
- fifo_full  input  1  RX FIFO full flag.
- rx_data  output  DATA_BITS  received byte; valid while `rx_push` is high, held afterwards.
- rx_push  output  1  one-clk push strobe to the RX FIFO.
- frame_err  output  1  one-clk pulse: stop bit sampled low.
- overrun  output  1  one-clk pulse: good byte dropped because `fifo_full` was high.
- rx_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous)
  - `rx_data`=0, `rx_push`=0, `frame_err`=0, `overrun`=0, `rx_busy`=0.
  - Synchroniser flops=1, state=IDLE, counters=0.
  - Reset asserted mid-frame aborts the frame; no push, no error pulse.
- Input synchroniser
  - `rx_bit` passes through 2 flops on clk to give `rx_s`; add 2 clk latency.
  - All state decisions use `rx_s` only.
  - Counters advance only on `sample_tick`=1 clk edges. Exception: IDLE start detection acts on any clk.
- IDLE
  - `rx_s`=0 → tick_cnt=0, go to START.
- START
  - On each tick, tick_cnt++.
  - When tick_cnt reaches OVERSAMPLE/2−1 (mid start bit), sample `rx_s`.
  - Sample 0 → tick_cnt=0, bit_cnt=0, go to DATA.
  - Sample 1 → glitch: back to IDLE, no outputs.
- DATA
  - On each tick, tick_cnt++.
  - When tick_cnt = OVERSAMPLE−1: shift `rx_s` into shift register bit[bit_cnt] (LSB first) and set tick_cnt=0.
  - If bit_cnt = DATA_BITS−1 → go to STOP; else bit_cnt++.
- STOP
  - Sample at tick_cnt = OVERSAMPLE−1.
  - Stop=1, `fifo_full`=0 → next clk: `rx_data`=shift, `rx_push`=1 for 1 clk. Go to IDLE.
  - Stop=1, `fifo_full`=1 → `overrun`=1 for 1 clk, no push, `rx_data` unchanged. Go to IDLE.
  - Stop=0 → `frame_err`=1 for 1 clk, no push. Go to BREAK.
- BREAK
  - Stay until `rx_s`=1, then IDLE.
  - A held-low line (break) therefore yields exactly one `frame_err`, not repeated frames.
- Latency: `rx_push` rises 1 clk after the stop-bit sample tick. That is ≈ (1.5 + DATA_BITS) bit periods + 3 clk after the start edge on `rx_bit`.
- Back-to-back frames: a new start edge seen in the clk after returning to IDLE must be accepted; zero idle bits between frames is supported.
- `sample_tick` stuck low freezes the FSM in its current state; this is not an error.
- Counter widths: tick_cnt = clog2(OVERSAMPLE), bit_cnt = clog2(DATA_BITS); wrap-around never occurs because explicit compares reset both counters.

Decomposition:
- Shared package `uart_pkg`:
  - RX state encodings: IDLE, START, DATA, STOP, BREAK (3 bits).
  - Wishbone address constants: TX=0x0, RX=0x1, FREQ_DIV=0x2.
  - HIGH/LOW constants.
  - Default OVERSAMPLE=16.
- One sub-module: `uart_sync2`, a 2-flop synchroniser.
  - Async active-low reset to 1; reusable for any asynchronous input.

Test Plan:
- Bench setup: `sample_tick` every 4 clk, OVERSAMPLE=16, so 1 bit = 64 clk.
- Frame 0x55 with stop=1 → single `rx_push` pulse with `rx_data`=0x55; `frame_err`=`overrun`=0; `rx_busy` low afterwards.
- 20-clk low glitch on idle line → START aborts; no `rx_push`, no `frame_err`; `rx_busy` pulses then 0.
- Frame 0xA3 with stop bit driven 0, then line held low 500 clk → exactly one `frame_err` pulse, no push; `rx_busy`=1 until line returns high.
- `fifo_full`=1 during frame 0x3C → one `overrun` pulse, no `rx_push`, `rx_data` keeps previous value.
- Reset asserted at data bit 4 of 0xF0, released, then frame 0x81 → no output for the aborted frame; `rx_push` with 0x81.
- Back-to-back 0x00 then 0xFF, no idle gap → two pushes, 0x00 then 0xFF, no errors.
